// File: rtl/dram_ctrl.sv
// rtl/dram_ctrl.sv - single-bank DRAM controller with open-row policy
// Registered DRAM pins; one request in flight; read data held until consumed.
module dram_ctrl #(
   parameter int TRP  = 5,
   parameter int TRCD = 5,
   parameter int TWR  = 5
) (
   input  logic        dram_clk,
   input  logic        dram_rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [20:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wstrb,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        DRAM_CSn,
   output logic        DRAM_RASn,
   output logic        DRAM_CASn,
   output logic [3:0]  DRAM_WEn,
   output logic [10:0] DRAM_A,
   output logic [31:0] DRAM_D,
   input  logic [31:0] DRAM_Q,
   input  logic        DRAM_valid
);

   localparam int CW = 8;

   typedef enum logic [2:0] {
      S_IDLE, S_PRE, S_ACT, S_CAS, S_WAIT_RP, S_WAIT_RCD, S_WAIT_RD, S_WAIT_WR
   } state_t;

   typedef enum logic [2:0] {C_NOP, C_PRE, C_ACT, C_RD, C_WR} cmd_t;

   state_t        state, state_nxt;
   cmd_t          cmd;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          rsp_valid_nxt, req_ready_nxt, capture, hs;

   logic          lat_write;
   logic [20:0]   lat_addr;
   logic [31:0]   lat_wdata;
   logic [3:0]    lat_wstrb;
   logic          row_open;
   logic [10:0]   open_row;

   logic          cur_write;
   logic [10:0]   cur_row;
   logic [9:0]    cur_col;
   logic [31:0]   cur_wdata;
   logic [3:0]    cur_wstrb;

   assign hs = req_valid && req_ready;

   // A row-hit CAS goes out on the handshake edge, before the latch is loaded.
   always_comb begin
      cur_write = lat_write;
      cur_row   = lat_addr[20:10];
      cur_col   = lat_addr[9:0];
      cur_wdata = lat_wdata;
      cur_wstrb = lat_wstrb;
      if (state == S_IDLE) begin
         cur_write = req_write;
         cur_row   = req_addr[20:10];
         cur_col   = req_addr[9:0];
         cur_wdata = req_wdata;
         cur_wstrb = req_wstrb;
      end
   end

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      cmd           = C_NOP;
      capture       = 1'b0;
      rsp_valid_nxt = rsp_valid;
      if (rsp_valid && rsp_ready)
         rsp_valid_nxt = 1'b0;
      case (state)
         S_IDLE: begin
            if (hs) begin
               if (row_open && open_row == cur_row) begin
                  state_nxt = S_CAS;
                  cmd       = cur_write ? C_WR : C_RD;
               end else if (row_open) begin
                  state_nxt = S_PRE;
                  cmd       = C_PRE;
               end else begin
                  state_nxt = S_ACT;
                  cmd       = C_ACT;
               end
            end
         end
         S_PRE: begin
            state_nxt = S_WAIT_RP;
            cnt_nxt   = CW'(TRP - 1);
         end
         S_WAIT_RP: begin
            if (cnt == '0) begin
               state_nxt = S_ACT;
               cmd       = C_ACT;
            end else begin
               cnt_nxt = cnt - CW'(1);
            end
         end
         S_ACT: begin
            state_nxt = S_WAIT_RCD;
            cnt_nxt   = CW'(TRCD - 1);
         end
         S_WAIT_RCD: begin
            if (cnt == '0) begin
               state_nxt = S_CAS;
               cmd       = cur_write ? C_WR : C_RD;
            end else begin
               cnt_nxt = cnt - CW'(1);
            end
         end
         S_CAS: begin
            if (cur_write) begin
               state_nxt = S_WAIT_WR;
               cnt_nxt   = CW'(TWR - 1);
            end else begin
               state_nxt = S_WAIT_RD;
            end
         end
         S_WAIT_RD: begin
            if (DRAM_valid) begin
               capture       = 1'b1;
               rsp_valid_nxt = 1'b1;
               state_nxt     = S_IDLE;
            end
         end
         S_WAIT_WR: begin
            if (cnt == '0)
               state_nxt = S_IDLE;
            else
               cnt_nxt = cnt - CW'(1);
         end
         default: state_nxt = S_IDLE;
      endcase
      req_ready_nxt = (state_nxt == S_IDLE) && !rsp_valid_nxt;
   end

   always_ff @(posedge dram_clk or negedge dram_rst_n) begin
      if (!dram_rst_n) begin
         state     <= S_IDLE;
         cnt       <= '0;
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         lat_write <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_wstrb <= '0;
         row_open  <= 1'b0;
         open_row  <= '0;
         DRAM_CSn  <= 1'b1;
         DRAM_RASn <= 1'b1;
         DRAM_CASn <= 1'b1;
         DRAM_WEn  <= 4'hF;
         DRAM_A    <= '0;
         DRAM_D    <= '0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         req_ready <= req_ready_nxt;
         rsp_valid <= rsp_valid_nxt;
         if (capture)
            rsp_rdata <= DRAM_Q;
         if (hs) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_wstrb <= req_wstrb;
         end
         // Address and data buses hold their last value through NOPs.
         DRAM_CSn  <= 1'b1;
         DRAM_RASn <= 1'b1;
         DRAM_CASn <= 1'b1;
         DRAM_WEn  <= 4'hF;
         case (cmd)
            C_PRE: begin
               DRAM_CSn  <= 1'b0;
               DRAM_RASn <= 1'b0;
               DRAM_WEn  <= 4'h0;
               row_open  <= 1'b0;
            end
            C_ACT: begin
               DRAM_CSn  <= 1'b0;
               DRAM_RASn <= 1'b0;
               DRAM_A    <= cur_row;
               row_open  <= 1'b1;
               open_row  <= cur_row;
            end
            C_RD: begin
               DRAM_CSn  <= 1'b0;
               DRAM_CASn <= 1'b0;
               DRAM_A    <= {1'b0, cur_col};
            end
            C_WR: begin
               DRAM_CSn  <= 1'b0;
               DRAM_CASn <= 1'b0;
               DRAM_WEn  <= ~cur_wstrb;
               DRAM_A    <= {1'b0, cur_col};
               DRAM_D    <= cur_wdata;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/dram_ctrl.md
DRAM_CTRL -- requirements
Module: dram_ctrl

Interface
REQ-001 SHALL have parameter TRP, default 5: number of dram_clk cycles from a precharge command to the next activate.
REQ-002 SHALL have parameter TRCD, default 5: number of cycles from an activate to the first CAS command.
REQ-003 SHALL have parameter TWR, default 5: number of cycles after a write CAS before any precharge.
REQ-004 SHALL have port dram_clk, input, 1: the single clock; the block runs only in the DRAM clock domain.
REQ-005 SHALL have port dram_rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port req_valid, input, 1: a request is present.
REQ-007 SHALL have port req_ready, output, 1: the controller accepts a request on this cycle.
REQ-008 SHALL have port req_write, input, 1: 1 = write, 0 = read.
REQ-009 SHALL have port req_addr, input, 21: word address; row = [20:10], column = [9:0].
REQ-010 SHALL have port req_wdata, input, 32: write data.
REQ-011 SHALL have port req_wstrb, input, 4: byte enables, active-high.
REQ-012 SHALL have port rsp_valid, output, 1: read data is available.
REQ-013 SHALL have port rsp_ready, input, 1: the consumer accepts the read data.
REQ-014 SHALL have port rsp_rdata, output, 32: read data.
REQ-015 SHALL have DRAM pin ports: DRAM_CSn, DRAM_RASn and DRAM_CASn as 1-bit outputs, DRAM_WEn as a 4-bit output, DRAM_A as an 11-bit output, DRAM_D as a 32-bit output, DRAM_Q as a 32-bit input and DRAM_valid as a 1-bit input.

Function
REQ-016 SHALL drive every DRAM pin output from a register.
REQ-017 SHALL define the idle (NOP) pin state as CSn=1, RASn=1, CASn=1, WEn=4'hF.
REQ-018 SHALL issue commands with CSn=0 and these pins, each for exactly one cycle:
- PRE: RASn=0, CASn=1, WEn=4'h0.
- ACT: RASn=0, CASn=1, WEn=4'hF, A=row.
- RD: RASn=1, CASn=0, WEn=4'hF, A={1'b0,col}.
- WR: RASn=1, CASn=0, WEn=~req_wstrb, A={1'b0,col}, D=wdata.
REQ-019 SHALL implement the FSM IDLE -> {PRE, ACT, CAS} -> WAIT_RP / WAIT_RCD / WAIT_RD / WAIT_WR -> IDLE, with one counter shared by all tRP, tRCD and tWR waits.
REQ-020 SHALL assert req_ready only in IDLE when rsp_valid is 0; a handshake is req_valid&&req_ready, and the controller SHALL latch write, addr, wdata and wstrb at the handshake.
REQ-021 SHALL use an open-row policy: keep the last activated row open and track it with a row_open flag and a row register.
REQ-022 SHALL, on a row hit (row_open and equal row), issue the CAS in the cycle after the handshake.
REQ-023 SHALL, on a row miss with a row open, sequence PRE, then TRP cycles, then ACT, then TRCD cycles, then CAS.
REQ-024 SHALL, when no row is open, sequence ACT, then TRCD cycles, then CAS.
REQ-025 SHALL, after a read CAS, wait in WAIT_RD until DRAM_valid=1.
REQ-026 SHALL capture DRAM_Q into rsp_rdata on that same cycle and set rsp_valid to 1 on the next cycle.
REQ-027 SHALL hold rsp_valid and rsp_rdata stable until rsp_ready=1, and clear rsp_valid in the cycle after the handshake.
REQ-028 SHALL accept a new request no earlier than the cycle rsp_valid clears.
REQ-029 SHALL, after a write CAS, spend TWR cycles in WAIT_WR before returning to IDLE.
REQ-030 SHALL produce no response for a write.
REQ-031 SHALL, for a write with req_wstrb=4'h0, still issue the WR command with WEn=4'hF.
REQ-032 SHALL keep DRAM_A and DRAM_D at their last values during NOP cycles.
REQ-033 SHALL ignore DRAM_valid in every state except WAIT_RD.
REQ-034 SHALL treat a request whose row equals the open row exactly as a row hit, including row 0 and column 10'h3FF.

Reset
REQ-035 SHALL, while dram_rst_n=0, immediately force: the NOP pin state, DRAM_A=0, DRAM_D=0, req_ready=0, rsp_valid=0, rsp_rdata=0, row_open=0, FSM=IDLE, counter=0.
REQ-036 SHALL abandon any in-flight operation when reset asserts mid-operation, and SHALL keep no open row after reset.
REQ-037 SHALL assert req_ready on the first dram_clk edge after dram_rst_n deasserts.

Verification
REQ-038 SHALL cover: after reset, read addr 21'h000400 -> ACT with A=11'h001, then after TRCD cycles RD with A=11'h000; DRAM_valid with Q=32'hDEADBEEF -> rsp_rdata=32'hDEADBEEF.
REQ-039 SHALL cover: write 21'h000405, wdata 32'h12345678, wstrb 4'b0101 -> no ACT (row hit), WR with WEn=4'b1010, A=11'h005, D=32'h12345678, then TWR idle cycles.
REQ-040 SHALL cover: read 21'h1FFC00 with row 11'h001 open -> PRE, exactly TRP NOP cycles, ACT with A=11'h7FF, TRCD NOPs, RD with A=11'h000.
REQ-041 SHALL cover: rsp_ready held 0 for 10 cycles -> rsp_valid and rsp_rdata stable, req_ready=0, no command issued during that time.
REQ-042 SHALL cover: dram_rst_n pulsed low during WAIT_RCD -> pins return to NOP within the same cycle; the next request to the same row issues ACT first.
REQ-043 SHALL cover: DRAM_valid pulsed high while in IDLE or WAIT_WR -> no rsp_valid.
